// File: rtl/instr_encoder_writer_if.sv
// Handshake + instruction-memory write bus for the instruction encoder/writer.
// master = program loader (drives ops and session pulses), slave = writer.
interface instr_encoder_writer_if #(
    parameter int ADDR_W = 6
);
    logic              start;
    logic              finish;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        op_sel;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [25:0]       imm;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic [ADDR_W:0]   prog_len;
    logic              done;
    logic              err;

    modport master (
        output start, finish, in_valid, op_sel, rs, rt, rd, imm,
        input  in_ready, wr_en, wr_addr, wr_data, prog_len, done, err
    );

    modport slave (
        input  start, finish, in_valid, op_sel, rs, rt, rd, imm,
        output in_ready, wr_en, wr_addr, wr_data, prog_len, done, err
    );
endinterface

// File: rtl/instr_encoder_writer.sv
// Encodes symbolic ops into MIPS words and writes them sequentially into
// instruction memory, one registered write per accepted legal op.
module instr_encoder_writer #(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    instr_encoder_writer_if.slave   bus_io
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    logic [1:0]        state_q,    state_d;
    logic [ADDR_W:0]   prog_len_q, prog_len_d;
    logic              wr_en_q,    wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q,  wr_addr_d;
    logic [31:0]       wr_data_q,  wr_data_d;
    logic              err_q,      err_d;

    logic              accept;
    logic              enc_legal;
    logic [31:0]       enc_word;
    logic [ADDR_W:0]   len_inc;

    assign bus_io.in_ready = (state_q == ST_RUN);
    assign bus_io.done     = (state_q == ST_DONE);
    assign bus_io.wr_en    = wr_en_q;
    assign bus_io.wr_addr  = wr_addr_q;
    assign bus_io.wr_data  = wr_data_q;
    assign bus_io.prog_len = prog_len_q;
    assign bus_io.err      = err_q;

    // Session pulses take the cycle: an op presented alongside them is dropped.
    assign accept  = bus_io.in_valid && bus_io.in_ready && !bus_io.start && !bus_io.finish;
    assign len_inc = prog_len_q + 1'b1;

    always_comb begin
        enc_legal = 1'b1;
        enc_word  = '0;
        case (bus_io.op_sel)
            4'd0:  enc_word = {6'h00, bus_io.rs, bus_io.rt, bus_io.rd, 5'd0, 6'h20};
            4'd1:  enc_word = {6'h00, bus_io.rs, bus_io.rt, bus_io.rd, 5'd0, 6'h22};
            4'd2:  enc_word = {6'h00, bus_io.rs, bus_io.rt, bus_io.rd, 5'd0, 6'h24};
            4'd3:  enc_word = {6'h00, bus_io.rs, bus_io.rt, bus_io.rd, 5'd0, 6'h25};
            4'd4:  enc_word = {6'h00, bus_io.rs, bus_io.rt, bus_io.rd, 5'd0, 6'h2A};
            4'd5:  enc_word = {6'h23, bus_io.rs, bus_io.rt, bus_io.imm[15:0]};
            4'd6:  enc_word = {6'h2B, bus_io.rs, bus_io.rt, bus_io.imm[15:0]};
            4'd7:  enc_word = {6'h04, bus_io.rs, bus_io.rt, bus_io.imm[15:0]};
            4'd8:  enc_word = {6'h05, bus_io.rs, bus_io.rt, bus_io.imm[15:0]};
            4'd9:  enc_word = {6'h02, bus_io.imm};
            4'd10: enc_word = {6'h08, bus_io.rs, bus_io.rt, bus_io.imm[15:0]};
            default: enc_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        prog_len_d = prog_len_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        err_d      = err_q;
        if (bus_io.start) begin
            state_d    = ST_RUN;
            prog_len_d = '0;
            wr_addr_d  = '0;
            err_d      = 1'b0;
        end else if (bus_io.finish) begin
            if (state_q == ST_RUN) state_d = ST_DONE;
        end else if (accept) begin
            if (enc_legal) begin
                wr_en_d    = 1'b1;
                wr_addr_d  = prog_len_q[ADDR_W-1:0];
                wr_data_d  = enc_word;
                prog_len_d = len_inc;
                // Leave RUN on the same edge so no op can target an address >= DEPTH.
                if (len_inc == DEPTH_L) state_d = ST_DONE;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            prog_len_q <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            prog_len_q <= prog_len_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            err_q      <= err_d;
        end
    end
endmodule

// File: tb/tb_instr_encoder_writer.sv
// Self-checking bench for instr_encoder_writer: directed scenarios plus a
// randomized run against a behavioural model of the load session.
module tb_instr_encoder_writer;
    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    instr_encoder_writer_if #(.ADDR_W(6)) bus ();
    instr_encoder_writer_if #(.ADDR_W(3)) sbus ();

    instr_encoder_writer #(.ADDR_W(6), .DEPTH(64)) u_dut (
        .clk_i(clk), .reset_i(reset), .bus_io(bus.slave));
    instr_encoder_writer #(.ADDR_W(3), .DEPTH(4)) u_small (
        .clk_i(clk), .reset_i(reset), .bus_io(sbus.slave));

    function automatic logic [31:0] ref_word(int op, int rs, int rt, int rd, int imm);
        longint w;
        int funct[5] = '{32, 34, 36, 37, 42};
        w = 0;
        if (op <= 4)
            w = rs * 2**21 + rt * 2**16 + rd * 2**11 + funct[op];
        else if (op == 9)
            w = 2 * longint'(2**26) + (imm % 2**26);
        else if (op <= 10) begin
            longint opc;
            case (op)
                5: opc = 35;
                6: opc = 43;
                7: opc = 4;
                8: opc = 5;
                default: opc = 8;
            endcase
            w = opc * longint'(2**26) + rs * 2**21 + rt * 2**16 + (imm % 65536);
        end
        return w[31:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start = 0; bus.finish = 0; bus.in_valid = 0;
        bus.op_sel = 0; bus.rs = 0; bus.rt = 0; bus.rd = 0; bus.imm = 0;
        sbus.start = 0; sbus.finish = 0; sbus.in_valid = 0;
        sbus.op_sel = 0; sbus.rs = 0; sbus.rt = 0; sbus.rd = 0; sbus.imm = 0;
    endtask

    task automatic put_op(int op, int rs, int rt, int rd, int imm);
        bus.in_valid = 1; bus.op_sel = 4'(op);
        bus.rs = 5'(rs); bus.rt = 5'(rt); bus.rd = 5'(rd); bus.imm = 26'(imm);
    endtask

    task automatic pulse_start();
        bus.start = 1; sbus.start = 1;
        step();
        bus.start = 0; sbus.start = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        step(); step();
        reset = 0;
        step();
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
        n_cmp++; if (bus.wr_en !== 1'b0) begin n_bad++; $display("FAIL reset_wr_en: got %b want 0", bus.wr_en); end
        n_cmp++; if ({bus.wr_addr, bus.wr_data} !== '0) begin n_bad++; $display("FAIL reset_wr_bus: got %h/%h want 0/0", bus.wr_addr, bus.wr_data); end
        n_cmp++; if ({bus.prog_len, bus.done, bus.err} !== '0) begin n_bad++; $display("FAIL reset_status: got len=%0d done=%b err=%b want 0", bus.prog_len, bus.done, bus.err); end
    endtask

    task automatic test_first_add();
        pulse_start();
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL start_in_ready: got %b want 1", bus.in_ready); end
        put_op(0, 1, 2, 3, 0);
        step();
        bus.in_valid = 0;
        n_cmp++; if (bus.wr_en !== 1'b1) begin n_bad++; $display("FAIL add_wr_en: got %b want 1", bus.wr_en); end
        n_cmp++; if (bus.wr_addr !== 6'd0) begin n_bad++; $display("FAIL add_addr: got %0d want 0", bus.wr_addr); end
        n_cmp++; if (bus.wr_data !== 32'h00221820) begin n_bad++; $display("FAIL add_data: got %h want 00221820", bus.wr_data); end
        n_cmp++; if (bus.prog_len !== 7'd1) begin n_bad++; $display("FAIL add_len: got %0d want 1", bus.prog_len); end
        step();
        n_cmp++; if (bus.wr_en !== 1'b0) begin n_bad++; $display("FAIL add_one_shot: got %b want 0", bus.wr_en); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_d[4] = '{32'h8FA80004, 32'h1085FFFE, 32'h08100000, 32'h20097FFF};
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: put_op(5, 29, 8, 0, 'h0004);
                1: put_op(7, 4, 5, 0, 'h3FFFE);
                2: put_op(9, 7, 7, 7, 'h0100000);
                default: put_op(10, 0, 9, 0, 'h7FFF);
            endcase
            step();
            n_cmp++; if ({bus.wr_en, bus.wr_addr} !== {1'b1, 6'(i)}) begin n_bad++; $display("FAIL b2b_addr%0d: got en=%b addr=%0d want en=1 addr=%0d", i, bus.wr_en, bus.wr_addr, i); end
            n_cmp++; if (bus.wr_data !== exp_d[i]) begin n_bad++; $display("FAIL b2b_data%0d: got %h want %h", i, bus.wr_data, exp_d[i]); end
        end
        bus.in_valid = 0;
        step();
        n_cmp++; if ({bus.wr_en, bus.prog_len} !== {1'b0, 7'd4}) begin n_bad++; $display("FAIL b2b_end: got en=%b len=%0d want en=0 len=4", bus.wr_en, bus.prog_len); end
    endtask

    task automatic test_illegal();
        pulse_start();
        put_op(0, 3, 4, 5, 0);
        step();
        n_cmp++; if ({bus.wr_en, bus.wr_addr} !== {1'b1, 6'd0}) begin n_bad++; $display("FAIL ill_first: got en=%b addr=%0d want en=1 addr=0", bus.wr_en, bus.wr_addr); end
        put_op(12, 1, 1, 1, 1);
        step();
        n_cmp++; if (bus.wr_en !== 1'b0) begin n_bad++; $display("FAIL ill_no_write: got %b want 0", bus.wr_en); end
        n_cmp++; if ({bus.err, bus.prog_len, bus.in_ready} !== {1'b1, 7'd1, 1'b1}) begin n_bad++; $display("FAIL ill_status: got err=%b len=%0d rdy=%b want 1/1/1", bus.err, bus.prog_len, bus.in_ready); end
        put_op(0, 6, 7, 8, 0);
        step();
        bus.in_valid = 0;
        n_cmp++; if ({bus.wr_en, bus.wr_addr} !== {1'b1, 6'd1}) begin n_bad++; $display("FAIL ill_second: got en=%b addr=%0d want en=1 addr=1", bus.wr_en, bus.wr_addr); end
        n_cmp++; if (bus.wr_data !== ref_word(0, 6, 7, 8, 0)) begin n_bad++; $display("FAIL ill_second_data: got %h want %h", bus.wr_data, ref_word(0, 6, 7, 8, 0)); end
        step();
        n_cmp++; if ({bus.prog_len, bus.err} !== {7'd2, 1'b1}) begin n_bad++; $display("FAIL ill_end: got len=%0d err=%b want 2/1", bus.prog_len, bus.err); end
    endtask

    task automatic test_full();
        logic [31:0] q[$];
        int nwr = 0;
        pulse_start();
        for (int i = 0; i < 6; i++) begin
            int op = $urandom_range(0, 10);
            int a = $urandom_range(0, 31), b = $urandom_range(0, 31), c = $urandom_range(0, 31);
            int im = $urandom_range(0, 2**26 - 1);
            sbus.in_valid = 1; sbus.op_sel = 4'(op);
            sbus.rs = 5'(a); sbus.rt = 5'(b); sbus.rd = 5'(c); sbus.imm = 26'(im);
            if (i < 4) q.push_back(ref_word(op, a, b, c, im));
            step();
            n_cmp++; if (sbus.wr_en !== (i < 4)) begin n_bad++; $display("FAIL full_wr_en%0d: got %b want %b", i, sbus.wr_en, i < 4); end
            n_cmp++; if (sbus.in_ready !== (i < 3)) begin n_bad++; $display("FAIL full_ready%0d: got %b want %b", i, sbus.in_ready, i < 3); end
            if (sbus.wr_en === 1'b1) begin
                logic [31:0] e = (q.size() > 0) ? q.pop_front() : 32'hDEAD_BEEF;
                n_cmp++; if ({sbus.wr_addr, sbus.wr_data} !== {3'(nwr), e}) begin n_bad++; $display("FAIL full_write%0d: got %0d/%h want %0d/%h", i, sbus.wr_addr, sbus.wr_data, nwr, e); end
                nwr++;
            end
        end
        sbus.in_valid = 0;
        n_cmp++; if (nwr !== 4) begin n_bad++; $display("FAIL full_count: got %0d want 4", nwr); end
        n_cmp++; if ({sbus.done, sbus.prog_len} !== {1'b1, 4'd4}) begin n_bad++; $display("FAIL full_done: got done=%b len=%0d want 1/4", sbus.done, sbus.prog_len); end
    endtask

    task automatic test_finish_restart();
        pulse_start();
        put_op(13, 0, 0, 0, 0);
        step();
        put_op(1, 9, 10, 11, 0);
        step();
        put_op(2, 12, 13, 14, 0);
        step();
        n_cmp++; if ({bus.wr_en, bus.wr_addr} !== {1'b1, 6'd1}) begin n_bad++; $display("FAIL fin_pending: got en=%b addr=%0d want en=1 addr=1", bus.wr_en, bus.wr_addr); end
        bus.finish = 1;
        step();
        bus.finish = 0;
        n_cmp++; if ({bus.done, bus.prog_len, bus.wr_en, bus.in_ready} !== {1'b1, 7'd2, 1'b0, 1'b0}) begin n_bad++; $display("FAIL fin_done: got done=%b len=%0d en=%b rdy=%b want 1/2/0/0", bus.done, bus.prog_len, bus.wr_en, bus.in_ready); end
        step();
        n_cmp++; if ({bus.wr_addr, bus.prog_len, bus.err} !== {6'd1, 7'd2, 1'b1}) begin n_bad++; $display("FAIL fin_hold: got addr=%0d len=%0d err=%b want 1/2/1", bus.wr_addr, bus.prog_len, bus.err); end
        bus.in_valid = 0;
        pulse_start();
        n_cmp++; if ({bus.prog_len, bus.done, bus.err} !== {7'd0, 1'b0, 1'b0}) begin n_bad++; $display("FAIL restart_clear: got len=%0d done=%b err=%b want 0/0/0", bus.prog_len, bus.done, bus.err); end
        put_op(3, 1, 2, 3, 0);
        step();
        bus.in_valid = 0;
        n_cmp++; if ({bus.wr_en, bus.wr_addr} !== {1'b1, 6'd0}) begin n_bad++; $display("FAIL restart_addr: got en=%b addr=%0d want en=1 addr=0", bus.wr_en, bus.wr_addr); end
    endtask

    task automatic test_reset_mid();
        pulse_start();
        put_op(4, 5, 6, 7, 0);
        step();
        bus.in_valid = 0;
        reset = 1;
        step();
        reset = 0;
        n_cmp++; if (bus.wr_en !== 1'b0) begin n_bad++; $display("FAIL rstmid_wr_en: got %b want 0", bus.wr_en); end
        n_cmp++; if ({bus.in_ready, bus.wr_addr, bus.wr_data, bus.prog_len, bus.done, bus.err} !== '0) begin n_bad++; $display("FAIL rstmid_state: got rdy=%b addr=%0d data=%h len=%0d done=%b err=%b want all 0", bus.in_ready, bus.wr_addr, bus.wr_data, bus.prog_len, bus.done, bus.err); end
        put_op(0, 1, 1, 1, 0);
        step(); step();
        bus.in_valid = 0;
        n_cmp++; if ({bus.in_ready, bus.wr_en} !== 2'b00) begin n_bad++; $display("FAIL rstmid_idle: got rdy=%b en=%b want 0/0", bus.in_ready, bus.wr_en); end
    endtask

    task automatic test_random();
        int len = 0, run = 0, dn = 0, er = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            int st = ($urandom_range(0, 59) == 0) || (cyc == 0);
            int fi = ($urandom_range(0, 39) == 0);
            int vl = ($urandom_range(0, 9) < 7);
            int op = ($urandom_range(0, 9) == 0) ? $urandom_range(11, 15) : $urandom_range(0, 10);
            int a = $urandom_range(0, 31), b = $urandom_range(0, 31), c = $urandom_range(0, 31);
            int im = $urandom_range(0, 2**26 - 1);
            int exp_wr = 0, exp_addr = 0;
            logic [31:0] exp_data = '0;
            bus.start = st[0]; bus.finish = fi[0];
            put_op(op, a, b, c, im);
            bus.in_valid = vl[0];
            if (st) begin run = 1; dn = 0; len = 0; er = 0; end
            else if (fi) begin if (run) begin run = 0; dn = 1; end end
            else if (vl && run) begin
                if (op <= 10) begin
                    exp_wr = 1; exp_addr = len; exp_data = ref_word(op, a, b, c, im);
                    len++;
                    if (len == 64) begin run = 0; dn = 1; end
                end else er = 1;
            end
            step();
            n_cmp++; if (bus.wr_en !== exp_wr[0]) begin n_bad++; $display("FAIL rnd_wr_en@%0d: got %b want %0d", cyc, bus.wr_en, exp_wr); end
            if (exp_wr != 0) begin
                n_cmp++; if ({bus.wr_addr, bus.wr_data} !== {6'(exp_addr), exp_data}) begin n_bad++; $display("FAIL rnd_write@%0d: got %0d/%h want %0d/%h", cyc, bus.wr_addr, bus.wr_data, exp_addr, exp_data); end
            end
            n_cmp++; if ({bus.prog_len, bus.in_ready, bus.done, bus.err} !== {7'(len), run[0], dn[0], er[0]}) begin n_bad++; $display("FAIL rnd_status@%0d: got len=%0d rdy=%b done=%b err=%b want %0d/%0d/%0d/%0d", cyc, bus.prog_len, bus.in_ready, bus.done, bus.err, len, run, dn, er); end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_first_add();
        test_back_to_back();
        test_illegal();
        test_full();
        test_finish_restart();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/instr_encoder_writer.md
Name: instr_encoder_writer

Overview:
- Instruction-side counterpart of the single-cycle control decoder. It takes symbolic operations (op select, registers, immediate) over a valid/ready handshake and encodes each one into a 32-bit MIPS word.
- It writes the encoded words sequentially into instruction memory, so programs can be loaded at bring-up.
- It produces exactly the opcode/funct encodings that the control decoder consumes: ADD, SUB, AND, OR, SLT, LW, SW, BEQ, BNE, J, ADDI.

Parameters:
ADDR_W, 6, width of the instruction-memory word address
DEPTH, 64, number of words the writer may fill; must satisfy 1 <= DEPTH <= 2^ADDR_W

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  single-cycle pulse; clears the address counter and begins a load session
finish  input  1  single-cycle pulse; ends the session
in_valid  input  1  operation present
in_ready  output  1  writer accepts an operation this cycle
op_sel  input  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 LW, 6 SW, 7 BEQ, 8 BNE, 9 J, 10 ADDI, 11-15 illegal
rs  input  5  source register
rt  input  5  second source register, or destination for LW/ADDI
rd  input  5  R-type destination register
imm  input  26  low 16 bits used for I-type; all 26 bits used for J
wr_en  output  1  instruction-memory write strobe
wr_addr  output  ADDR_W  write word address
wr_data  output  32  encoded instruction
prog_len  output  ADDR_W+1  number of words written in the current session
done  output  1  session ended (finish received or memory full)
err  output  1  sticky flag: an illegal op_sel was accepted

Behaviour:
- Reset values:
  - state IDLE; in_ready=0, wr_en=0, wr_addr=0, wr_data=0, prog_len=0, done=0, err=0.
  - Reset mid-session aborts the session; no further writes occur.
- States:
  - IDLE: in_ready=0.
  - RUN: in_ready=1.
  - DONE: in_ready=0, done=1.
- Transitions:
  - start in any state -> RUN. This clears prog_len, done and err.
  - RUN + finish -> DONE.
  - RUN + accepted legal op that makes prog_len reach DEPTH -> DONE.
  - DONE persists until start or reset.
- Handshake:
  - An operation is accepted when in_valid && in_ready.
  - If start or finish is asserted in the same cycle, in_valid is ignored (no accept). start has priority over finish.
- Latency:
  - An accepted legal op produces wr_en=1 for exactly one cycle, in the following cycle.
  - In that write cycle, wr_addr = prog_len value before the increment, and wr_data = the encoded word.
  - prog_len increments in the same edge that registers the write.
  - wr_en is 0 in every cycle with no accept.
- Back-to-back: one accept per cycle is allowed, giving one write per cycle at consecutive addresses.
- Encoding, R-type (ADD/SUB/AND/OR/SLT):
  - Fields: {6'h00, rs, rt, rd, 5'd0, funct}.
  - funct: ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, SLT 0x2A.
- Encoding, I-type:
  - Fields: {opcode, rs, rt, imm[15:0]}.
  - opcode: LW 0x23, SW 0x2B, BEQ 0x04, BNE 0x05, ADDI 0x08.
  - imm[25:16] is ignored.
- Encoding, J:
  - Fields: {6'h02, imm[25:0]}; rs, rt and rd are ignored.
- Illegal op_sel (11-15):
  - The op is accepted (handshake completes) but nothing is written.
  - err is set; prog_len is unchanged; the state is unchanged.
- Full:
  - The write that brings prog_len to DEPTH is performed.
  - The state becomes DONE in the same edge, so in_ready=0 in the write cycle.
  - No write ever targets an address >= DEPTH.
- finish in the same cycle as a pending write (an accept in the previous cycle): the write still completes and counts in prog_len.
- prog_len and wr_addr hold their values in DONE and IDLE until start or reset.

Test Plan:
- reset, start, then accept op_sel=0, rs=1, rt=2, rd=3 -> next cycle wr_en=1, wr_addr=0, wr_data=0x00221820; prog_len=1.
- back-to-back accepts:
  - LW, rs=29, rt=8, imm=0x0004 -> wr_data=0x8FA80004 at addr 0.
  - BEQ, rs=4, rt=5, imm=0x3FFFE -> wr_data=0x1085FFFE at addr 1 (upper imm ignored).
  - J, imm=0x0100000 -> wr_data=0x08100000 at addr 2.
  - ADDI, rt=9, rs=0, imm=0x7FFF -> wr_data=0x20097FFF at addr 3.
- op_sel=12 accepted between two ADDs -> no write for it, err=1, the two ADDs land at addrs 0 and 1, prog_len=2.
- DEPTH=4, in_valid held high for 6 cycles -> exactly 4 writes at addrs 0-3; in_ready falls in the 4th write cycle; done=1; prog_len=4.
- finish after 2 writes, then start -> done=1 with prog_len=2; after start, prog_len=0, done=0, err=0, and the next write lands at addr 0.
- reset asserted in the cycle after an accept -> wr_en=0 on the following edge, all outputs at their reset values, in_ready=0 until start.
